// File: rtl/fetch_queue_n_pkg.sv
// Shared fetch-side definitions: fault bit positions, default instruction
// width and the pre-decode info field layout agreed with the decoder.
package fetch_pkg;

    // Fault bit positions within the 2-bit packet fault field.
    localparam int FAULT_FETCH = 0;
    localparam int FAULT_PAGE  = 1;

    // Default instruction slot width.
    localparam int INSTR_W_DEF = 32;

    // Per-lane pre-decode info layout (11 bits total).
    localparam int INFO_W_DEF    = 11;
    localparam int INFO_INVALID  = 0;
    localparam int INFO_EXEC     = 1;
    localparam int INFO_LSU      = 2;
    localparam int INFO_BRANCH   = 3;
    localparam int INFO_MUL      = 4;
    localparam int INFO_DIV      = 5;
    localparam int INFO_CSR      = 6;
    localparam int INFO_MULF_LSB = 7;
    localparam int INFO_MULF_W   = 3;
    localparam int INFO_RD_VALID = 10;

endpackage

// File: rtl/fetch_queue_n_if.sv
// Fetch -> issue queue bus: packet push side, head/pop side and status.
//
// Handshake: a packet transfers on a rising edge where push_i and accept_o
// are both high (accept_o depends only on registered state, never on pop_i).
// A head lane k transfers on an edge where valid_o[k] and pop_i[k] are both
// high; pop_i[k] without valid_o[k] has no effect. flush_i drops everything.
interface fetch_queue_n_if
    import fetch_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int INFO_W  = INFO_W_DEF,
    parameter int ADDR_W  = 2
);
    logic                      flush_i;
    logic                      push_i;
    logic [31:0]               pc_in_i;
    logic [LANES-1:0]          mask_in_i;
    logic [1:0]                fault_in_i;
    logic [LANES*INSTR_W-1:0]  data_in_i;
    logic [LANES*INFO_W-1:0]   info_in_i;
    logic                      accept_o;
    logic [LANES-1:0]          valid_o;
    logic [LANES*INSTR_W-1:0]  instr_o;
    logic [LANES*32-1:0]       pc_o;
    logic [LANES*INFO_W-1:0]   info_o;
    logic [LANES*2-1:0]        fault_o;
    logic [LANES-1:0]          pop_i;
    logic [ADDR_W:0]           count_o;
    logic                      almost_full_o;

    modport master (
        output flush_i, push_i, pc_in_i, mask_in_i, fault_in_i, data_in_i,
               info_in_i, pop_i,
        input  accept_o, valid_o, instr_o, pc_o, info_o, fault_o, count_o,
               almost_full_o
    );

    modport slave (
        input  flush_i, push_i, pc_in_i, mask_in_i, fault_in_i, data_in_i,
               info_in_i, pop_i,
        output accept_o, valid_o, instr_o, pc_o, info_o, fault_o, count_o,
               almost_full_o
    );
endinterface

// File: rtl/fetch_queue_n.sv
// Multi-lane fetch queue: stores whole fetch packets, lets issue drain the
// head lanes independently, and retires the head once no lane is left.
module fetch_queue_n
    import fetch_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int LANE_W    = 1,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int INFO_W    = INFO_W_DEF,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int AFULL_LVL = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fetch_queue_n_if.slave  q
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

    // Packet storage; only the PC bits above the lane/byte offset are kept.
    logic [LANES*INSTR_W-1:0] data_q  [DEPTH];
    logic [31:LANE_W+2]       pc_q    [DEPTH];
    logic [LANES*INFO_W-1:0]  info_q  [DEPTH];
    logic [1:0]               fault_q [DEPTH];
    logic [LANES-1:0]         lv_q    [DEPTH];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic             not_empty;
    logic             accept;
    logic             push_fire;
    logic             retire;
    logic [LANES-1:0] head_valid;
    logic [LANES-1:0] pop_eff;
    logic [LANES-1:0] remain;

    assign not_empty  = (count_q != '0);
    assign accept     = (count_q != DEPTH_C);
    assign head_valid = not_empty ? lv_q[rd_ptr_q] : '0;
    assign pop_eff    = q.pop_i & head_valid;
    assign remain     = head_valid & ~pop_eff;
    // Head retires when this cycle's pops leave none of its lanes valid.
    assign retire     = not_empty && (remain == '0);
    // An all-zero mask is accepted but nothing is written.
    assign push_fire  = q.push_i && accept && (q.mask_in_i != '0);

    // Next pointer/count from this cycle's push and retire.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (retire)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (push_fire) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (push_fire && !retire)      count_d = count_q + (ADDR_W+1)'(1);
        else if (!push_fire && retire) count_d = count_q - (ADDR_W+1)'(1);
    end

    // Pointer and occupancy registers; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || q.flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Lane valids, info and fault: cleared on reset, valids/info on flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                lv_q[i]    <= '0;
                info_q[i]  <= '0;
                fault_q[i] <= '0;
            end
        end else if (q.flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                lv_q[i]   <= '0;
                info_q[i] <= '0;
            end
        end else begin
            lv_q[rd_ptr_q] <= lv_q[rd_ptr_q] & ~pop_eff;
            // Push never targets the head slot while it holds live lanes.
            if (push_fire) begin
                lv_q[wr_ptr_q]    <= q.mask_in_i;
                info_q[wr_ptr_q]  <= q.info_in_i;
                fault_q[wr_ptr_q] <= q.fault_in_i;
            end
        end
    end

    // Instruction and PC storage; faulted packets store zero instructions.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            data_q[wr_ptr_q] <= (q.fault_in_i != 2'b00) ? '0 : q.data_in_i;
            pc_q[wr_ptr_q]   <= q.pc_in_i[31:LANE_W+2];
        end
    end

    assign q.accept_o      = accept;
    assign q.valid_o       = head_valid;
    assign q.instr_o       = data_q[rd_ptr_q];
    assign q.info_o        = info_q[rd_ptr_q];
    assign q.count_o       = count_q;
    assign q.almost_full_o = (count_q >= AFULL_C);

    // Per-lane PC and replicated fault bits for the head packet.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign q.fault_o[k*2 +: 2] = fault_q[rd_ptr_q];
        if (LANE_W > 0) begin : g_pc_multi
            assign q.pc_o[k*32 +: 32] = {pc_q[rd_ptr_q], LANE_W'(k), 2'b00};
        end else begin : g_pc_single
            assign q.pc_o[k*32 +: 32] = {pc_q[rd_ptr_q], 2'b00};
        end
    end

endmodule

// File: doc/fetch_queue_n.md
Name: fetch_queue_n

Overview:
- Parametrised successor to the two-slot fetch FIFO between fetch and issue.
- Each entry holds one fetch packet of LANES instruction slots, with a per-lane valid mask, pre-decode info and fault bits.
- Issue drains lanes independently. An entry retires when all of its lanes are consumed.
- Adds the following behaviour to the previous FIFO:
  - configurable depth and lane count;
  - per-lane push mask, replacing the single predicted-branch bit;
  - flush clears all lane valids;
  - count and almost-full outputs.

Parameters:
LANES, 2, instruction slots per fetch packet; power of 2, range 1..4
LANE_W, 1, log2(LANES); range 0..2; 0 when LANES=1
INSTR_W, 32, bits per instruction slot
INFO_W, 11, pre-decode info bits per lane
DEPTH, 4, entries; power of 2, minimum 2
ADDR_W, 2, log2(DEPTH)
AFULL_LVL, 3, count at or above which almost_full_o asserts; range 1..DEPTH

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  branch redirect; empties the queue
push_i  in  1  fetch packet valid
pc_in_i  in  32  fetch packet PC
mask_in_i  in  LANES  per-lane instruction valid
fault_in_i  in  2  {page, fetch} fault for the packet
data_in_i  in  LANES*INSTR_W  instructions; lane k at [k*INSTR_W +: INSTR_W]
info_in_i  in  LANES*INFO_W  per-lane pre-decode info
accept_o  out  1  queue can take a packet this cycle
valid_o  out  LANES  head lane k holds an unconsumed instruction
instr_o  out  LANES*INSTR_W  head instructions
pc_o  out  LANES*32  per-lane PC
info_o  out  LANES*INFO_W  head per-lane info
fault_o  out  LANES*2  head fault bits, replicated per lane
pop_i  in  LANES  issue consumes lane k
count_o  out  ADDR_W+1  occupied entries
almost_full_o  out  1  count_o >= AFULL_LVL

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high, sampled on the clk_i rising edge.
- Reset clears pointers, count, every lane-valid bit, info and fault storage.
  - After reset: valid_o=0, count_o=0, accept_o=1, almost_full_o=0, info_o=0, fault_o=0.
- accept_o = (count_o != DEPTH). It is purely registered state; there is no same-cycle pop-to-push bypass.
- Push fires when push_i & accept_o & (mask_in_i != 0).
  - A packet with an all-zero mask is accepted and dropped: nothing is written and count is unchanged.
  - On push, write at wr_ptr: data, pc, info, fault and lane valids = mask_in_i; wr_ptr increments modulo DEPTH.
  - If fault_in_i != 0, the stored data is zero for all lanes.
- Head outputs are combinational from rd_ptr.
  - valid_o[k] = (count != 0) & lane_valid[rd_ptr][k].
  - pc_o lane k = {pc[31:LANE_W+2], k[LANE_W-1:0], 2'b00}.
- Pop is effective when pop_i[k] & valid_o[k]; it clears lane_valid[rd_ptr][k].
  - pop_i[k] with valid_o[k]=0 is ignored.
  - Lanes may be popped in any order and in any combination within a cycle.
- Retire occurs when, after this cycle's effective pops, no lane of the head remains valid. rd_ptr then increments modulo DEPTH.
- Count update:
  - push without retire: +1;
  - retire without push: -1;
  - both or neither: unchanged.
- Full with a retire in the same cycle: no push that cycle, because accept_o was 0. The next cycle shows accept_o=1.
- Flush has priority over push and pop. It resets pointers and count, clears all lane valids and info, and takes effect at the next edge; the packet presented that cycle is dropped.
  - ram, pc and fault contents are don't-care after flush.
- Reset has priority over flush. Reset mid-operation discards all entries.
- Latency: a packet pushed at edge N is visible on valid_o after edge N, i.e. 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - fault bit indices: FAULT_FETCH=0, FAULT_PAGE=1;
  - INSTR_W default;
  - the info field layout constants shared with the decoder, covering invalid, exec, lsu, branch, mul, div, csr, mulf and rd_valid.
- No sub-module is needed. Lane handling is a generate loop in the single module.

Test Plan:
- Reset, then push pc=0x1000, mask=2'b11, data={0x00000013,0x00100093} -> next cycle valid_o=2'b11, pc_o lanes=0x1000/0x1004, count_o=1.
- With DEPTH=4, push 4 packets with no pop -> count_o=4, accept_o=0, almost_full_o=1 from count 3. A 5th push is not stored.
- Pop lane1 only, then lane0 next cycle -> head held after the first pop with valid_o=2'b01; retire after the second pop; count 4->3.
- Full queue, pop both head lanes while push_i=1 -> that push is dropped and count_o=3; the next cycle accept_o=1 and a push brings count to 4.
- Flush with 3 entries plus a concurrent push -> next cycle valid_o=0, count_o=0, accept_o=1; the pushed packet never appears.
- Push mask=2'b10 with fault_in_i=2'b01 -> valid_o=2'b10, instr lane1=0, fault_o lane1=2'b01. A push with mask=2'b00 leaves count_o unchanged.
- Push 10 packets with continuous single-cycle pops -> in-order PCs across pointer wrap, no loss or duplication.
